square_period_meter: RTL
========================

SQUARE_PERIOD_METER -- requirements
Module: square_period_meter

Interface
REQ-001 SHALL have parameter TOLERANCE, default 1, max |new period - previous period| (samples) still counted as a match.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-003 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-004 SHALL have port sample_valid  input  1  qualifies sample; logic advances only on cycles with sample_valid=1.
REQ-005 SHALL have port sample  input  32  signed audio sample (square-wave oscillator output).
REQ-006 SHALL have port wave_length  output  16  last committed full period, in valid samples.
REQ-007 SHALL have port amplitude  output  32  peak |sample| over last committed period.
REQ-008 SHALL have port period_valid  output  1  one-cycle pulse per committed period.
REQ-009 SHALL have port locked  output  1  high while consecutive periods match within TOLERANCE.

Function
REQ-010 SHALL classify each valid sample by sign bit: negative if sample[31]=1, otherwise non-negative (zero counts as non-negative).
REQ-011 SHALL define a rising transition as prev_sign negative -> current non-negative, and a falling transition as the reverse; prev_sign updates on every valid sample.
REQ-012 SHALL keep a 16-bit half_cnt: +1 per same-sign valid sample; set to 1 on any transition (the transition sample starts the new half).
REQ-013 SHALL implement states IDLE, ACQUIRE, LOCKED; locked=1 only in LOCKED.
REQ-014 IDLE: on rising transition -> ACQUIRE, clear have_pos and have_period flags, peak <= |sample|; no commit.
REQ-015 ACQUIRE/LOCKED, falling transition: pos_half <= half_cnt (pre-reset value), have_pos <= 1.
REQ-016 ACQUIRE/LOCKED, rising transition with have_pos=1: period = pos_half + half_cnt, computed 17-bit and saturated to 0xFFFF; commit wave_length <= period, amplitude <= peak, period_valid pulse; peak <= |sample|; have_pos <= 0.
REQ-017 Rising transition with have_pos=0 in ACQUIRE SHALL restart measurement (peak <= |sample|) without commit.
REQ-018 Commit in ACQUIRE: if have_period=1 and |period - wave_length(old)| <= TOLERANCE -> LOCKED; always have_period <= 1.
REQ-019 Commit in LOCKED: mismatch beyond TOLERANCE -> ACQUIRE (locked drops same cycle as period_valid); match stays LOCKED.
REQ-020 Non-transition valid samples SHALL update peak <= max(peak, |sample|); |-2^31| SHALL saturate to 0x7FFFFFFF.
REQ-021 Timeout: a valid same-sign sample with half_cnt=0xFFFF SHALL force IDLE, clear wave_length, amplitude, locked; no period_valid.
REQ-022 Outputs SHALL be registered: period_valid/wave_length/amplitude/locked change on the clock edge sampling the committing valid sample (1-cycle latency to visibility).
REQ-023 period_valid SHALL be 0 on every cycle without a commit, including sample_valid=0 cycles.
REQ-024 Cycles with sample_valid=0 SHALL hold all state; gaps SHALL not alter counts.

Reset
REQ-025 With reset_n=0 at a clock edge, SHALL enter IDLE, prev_sign non-negative, half_cnt=1, pos_half=0, peak=0, flags 0, wave_length=0, amplitude=0, period_valid=0, locked=0.
REQ-026 Reset SHALL take priority over sample_valid on the same cycle; reset mid-measurement discards partial halves.
REQ-027 First rising transition after reset requires a negative sample first (prev_sign resets non-negative).

Verification
REQ-028 Continuous square +/-0x100000, 4 pos / 4 neg, starting negative -> first period_valid at 2nd rising transition with wave_length=8, amplitude=0x00100000, locked=0; next commit locked=1.
REQ-029 Locked at 8, switch to 6 pos / 6 neg -> commit wave_length=12 with locked=0; following commit 12 -> locked=1.
REQ-030 Asymmetric 3 pos / 5 neg with sample_valid toggling every other cycle -> wave_length=8, same results as continuous stream.
REQ-031 Locked, then 65536 consecutive non-negative valid samples -> IDLE, wave_length=0, amplitude=0, locked=0, no period_valid.
REQ-032 Locked, reset_n=0 for one cycle with sample_valid=1 -> all outputs 0; relock requires two fresh matching commits.
REQ-033 Square with sample values 0 and -0x80000000, 4/4 -> wave_length=8, amplitude=0x7FFFFFFF.

Source files
------------

// File: rtl/square_period_meter_if.sv
// square_period_meter_if: sample stream in, period/amplitude measurements out.
//   sample_valid, sample      : qualified signed 32-bit audio samples (master -> slave)
//   wave_length, amplitude    : last committed period (samples) and its peak |sample|
//   period_valid, locked      : commit pulse and period-match lock flag (slave -> master)
interface square_period_meter_if;
    logic        sample_valid;
    logic [31:0] sample;
    logic [15:0] wave_length;
    logic [31:0] amplitude;
    logic        period_valid;
    logic        locked;
    modport master (output sample_valid, sample, input wave_length, amplitude, period_valid, locked);
    modport slave  (input sample_valid, sample, output wave_length, amplitude, period_valid, locked);
endinterface

// File: rtl/square_period_meter.sv
// square_period_meter: measures period and peak amplitude of a square-wave sample stream.
//   clk     : sole clock, everything on posedge
//   reset_n : synchronous active-low reset
//   bus     : slave side of square_period_meter_if (samples in, measurements out)
module square_period_meter #(
    parameter int TOLERANCE = 1
) (
    input logic                  clk,
    input logic                  reset_n,
    square_period_meter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        prev_neg_q, prev_neg_d;
    logic [15:0] half_cnt_q, half_cnt_d;
    logic [15:0] pos_half_q, pos_half_d;
    logic [31:0] peak_q, peak_d;
    logic        have_pos_q, have_pos_d;
    logic        have_period_q, have_period_d;
    logic [15:0] wave_length_q, wave_length_d;
    logic [31:0] amplitude_q, amplitude_d;
    logic        period_valid_q, period_valid_d;

    logic        neg, rise, fall, match;
    logic [31:0] mag;
    logic [16:0] sum;
    logic [15:0] period, diff;

    always_comb begin
        neg    = bus.sample[31];
        // -2^31 has no positive counterpart, so clamp it
        mag    = neg ? ((bus.sample == 32'h8000_0000) ? 32'h7FFF_FFFF : -bus.sample) : bus.sample;
        rise   = prev_neg_q & ~neg;
        fall   = ~prev_neg_q & neg;
        sum    = {1'b0, pos_half_q} + {1'b0, half_cnt_q};
        period = sum[16] ? 16'hFFFF : sum[15:0];
        diff   = (period > wave_length_q) ? period - wave_length_q : wave_length_q - period;
        // in LOCKED have_period is always set, so one test covers both states
        match  = have_period_q && ({16'd0, diff} <= 32'(TOLERANCE));
        state_d        = state_q;
        prev_neg_d     = prev_neg_q;
        half_cnt_d     = half_cnt_q;
        pos_half_d     = pos_half_q;
        peak_d         = peak_q;
        have_pos_d     = have_pos_q;
        have_period_d  = have_period_q;
        wave_length_d  = wave_length_q;
        amplitude_d    = amplitude_q;
        period_valid_d = 1'b0;
        if (bus.sample_valid) begin
            prev_neg_d = neg;
            if (!rise && !fall) begin
                half_cnt_d = (half_cnt_q == 16'hFFFF) ? half_cnt_q : half_cnt_q + 16'd1;
                peak_d     = (mag > peak_q) ? mag : peak_q;
                // a half that never ends means the input stopped oscillating
                if (half_cnt_q == 16'hFFFF) begin
                    state_d       = IDLE;
                    wave_length_d = 16'd0;
                    amplitude_d   = 32'd0;
                end
            end else begin
                half_cnt_d = 16'd1;
                if (fall && state_q != IDLE) begin
                    pos_half_d = half_cnt_q;
                    have_pos_d = 1'b1;
                end
                if (rise) begin
                    peak_d     = mag;
                    have_pos_d = 1'b0;
                    if (state_q == IDLE) begin
                        state_d       = ACQUIRE;
                        have_period_d = 1'b0;
                    end else if (have_pos_q) begin
                        wave_length_d  = period;
                        amplitude_d    = peak_q;
                        period_valid_d = 1'b1;
                        have_period_d  = 1'b1;
                        state_d        = match ? LOCKED : ACQUIRE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            prev_neg_q     <= 1'b0;
            half_cnt_q     <= 16'd1;
            pos_half_q     <= 16'd0;
            peak_q         <= 32'd0;
            have_pos_q     <= 1'b0;
            have_period_q  <= 1'b0;
            wave_length_q  <= 16'd0;
            amplitude_q    <= 32'd0;
            period_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_neg_q     <= prev_neg_d;
            half_cnt_q     <= half_cnt_d;
            pos_half_q     <= pos_half_d;
            peak_q         <= peak_d;
            have_pos_q     <= have_pos_d;
            have_period_q  <= have_period_d;
            wave_length_q  <= wave_length_d;
            amplitude_q    <= amplitude_d;
            period_valid_q <= period_valid_d;
        end
    end

    assign bus.wave_length  = wave_length_q;
    assign bus.amplitude    = amplitude_q;
    assign bus.period_valid = period_valid_q;
    assign bus.locked       = (state_q == LOCKED);
endmodule
